nonce_sweep_ctrl: RTL and testbench
===================================

NONCE_SWEEP_CTRL -- requirements
Module: nonce_sweep_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle sweep request, honoured only in IDLE
base_nonce  in  32  first nonce tried
nonce_count  in  16  number of nonces to try
msg_addr  in  16  header block base (word 19 = nonce slot)
out_addr  in  16  hash core digest base (word 0 = compared word)
target  in  32  success when digest word 0 <= target (unsigned)
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep end
found  out  1  valid with done: a nonce met target
found_nonce  out  32  winning nonce, held until next start
tried  out  16  nonces fully hashed this sweep
core_start  out  1  start to hash core
core_message_addr  out  16  equals msg_addr
core_output_addr  out  16  equals out_addr
core_done  in  1  hash core done (high when core idle)
core_mem_we  in  1  core write enable
core_mem_addr  in  16  core address
core_mem_write_data  in  32  core write data
mem_we  out  1  shared memory write enable
mem_addr  out  16  shared memory address
mem_write_data  out  32  shared memory write data
mem_read_data  in  32  shared memory read data, also wired to core
REQ-002 SHALL treat memory as synchronous: read data for address presented in cycle N is valid in cycle N+1; a write commits at the edge ending the cycle mem_we=1.

Function
REQ-003 SHALL implement FSM states IDLE, WNONCE, KICK, WLOW, RUN, DRAIN, RDREQ, CMP, FIN.
REQ-004 IDLE: start=1 and nonce_count!=0 -> WNONCE, nonce<=base_nonce, tried<=0, found<=0, busy<=1; start=1 and nonce_count=0 -> FIN; start=0 -> stay.
REQ-005 WNONCE: controller drives mem_we=1, mem_addr=msg_addr+19 (16-bit wrap), mem_write_data=nonce; -> KICK.
REQ-006 KICK: core_start=1 for exactly one cycle; -> WLOW.
REQ-007 WLOW: wait for core_done=0 (core accepted start); -> RUN.
REQ-008 RUN: wait for core_done=1; -> DRAIN.
REQ-009 DRAIN: one cycle; lets the core's final write commit; -> RDREQ.
REQ-010 From WLOW through DRAIN inclusive, mem_we/mem_addr/mem_write_data SHALL pass combinationally from core_mem_*; in all other states the controller owns the bus.
REQ-011 Controller-owned bus with no access in progress: mem_we=0, mem_addr=0, mem_write_data=0.
REQ-012 RDREQ: mem_addr=out_addr, mem_we=0; -> CMP.
REQ-013 CMP: tried<=tried+1.
- mem_read_data<=target: found<=1, found_nonce<=nonce, -> FIN.
- else tried+1=nonce_count: -> FIN.
- else nonce<=nonce+1 (32-bit wrap, 0xFFFFFFFF->0), -> WNONCE.
REQ-014 FIN: done=1 for one cycle, busy<=0; -> IDLE.
REQ-015 Per-nonce latency outside the core: WNONCE+KICK+DRAIN+RDREQ+CMP = 5 cycles plus WLOW/RUN wait time.
REQ-016 start while busy SHALL be ignored; input ports SHALL be sampled only in the IDLE start cycle (latched copies used thereafter).
REQ-017 core_start SHALL never assert outside KICK; core_message_addr/core_output_addr SHALL be the latched addresses.
REQ-018 tried, found, found_nonce SHALL hold after done until the next accepted start.

Reset
REQ-019 reset=1 at any edge, including mid-sweep, SHALL force: IDLE, busy=0, done=0, found=0, found_nonce=0, tried=0, core_start=0, controller bus mem_we=0/mem_addr=0/mem_write_data=0.
REQ-020 Reset SHALL override start in the same cycle; first start accepted is the one sampled the cycle after reset deasserts.

Verification
REQ-021 Bench SHALL cover, with a behavioural core model (done low 200 cycles, writes 8 digest words):
- base_nonce=0x10, nonce_count=3, target=0, digests all >0 -> nonces 0x10,0x11,0x12 written to msg_addr+19; done with found=0, tried=3.
- Model digest word0 = 0x00000005 for nonce 0x11, target=0x00000005 -> found=1, found_nonce=0x11, tried=2; no third core_start.
- nonce_count=0 -> done pulse 2 cycles after start, found=0, tried=0, core_start never asserted.
- base_nonce=0xFFFFFFFF, nonce_count=2, no hit -> second nonce written = 0x00000000.
- reset pulsed during RUN -> next cycle busy=0, core_start=0, mem_we=0; new start executes a clean sweep.
- start pulsed during RUN and during FIN -> ignored; exactly one done pulse per accepted start; mem_we never driven by controller in WLOW-DRAIN.

Source files
------------

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: writes successive nonces into the header block, runs the
// hash core on each, and stops on the first digest word 0 at or below target.
module nonce_sweep_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_nonce,
    input  logic [15:0] nonce_count,
    input  logic [15:0] msg_addr,
    input  logic [15:0] out_addr,
    input  logic [31:0] target,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] found_nonce,
    output logic [15:0] tried,
    output logic        core_start,
    output logic [15:0] core_message_addr,
    output logic [15:0] core_output_addr,
    input  logic        core_done,
    input  logic        core_mem_we,
    input  logic [15:0] core_mem_addr,
    input  logic [31:0] core_mem_write_data,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WNONCE = 4'd1,
        KICK   = 4'd2,
        WLOW   = 4'd3,
        RUN    = 4'd4,
        DRAIN  = 4'd5,
        RDREQ  = 4'd6,
        CMP    = 4'd7,
        FIN    = 4'd8
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic [31:0] nonce_r;
    logic [15:0] count_r;
    logic [15:0] msg_r;
    logic [15:0] out_r;
    logic [31:0] target_r;
    logic        busy_r;
    logic        done_r;
    logic        found_r;
    logic [31:0] found_nonce_r;
    logic [15:0] tried_r;

    logic        hit_s;
    logic        last_s;
    logic [15:0] tried_inc_s;

    // The digest word read in RDREQ arrives in CMP, so the compare uses the live read data.
    assign hit_s       = (mem_read_data <= target_r);
    assign tried_inc_s = tried_r + 16'd1;
    assign last_s      = (tried_inc_s == count_r);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (nonce_count != 16'd0) begin
                        state_s = WNONCE;
                    end else begin
                        state_s = FIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WNONCE: state_s = KICK;
            KICK:   state_s = WLOW;
            WLOW: begin
                if (!core_done) begin
                    state_s = RUN;
                end else begin
                    state_s = WLOW;
                end
            end
            RUN: begin
                if (core_done) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN:  state_s = RDREQ;
            RDREQ:  state_s = CMP;
            CMP: begin
                if (hit_s || last_s) begin
                    state_s = FIN;
                end else begin
                    state_s = WNONCE;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode: core kick and shared-bus ownership
    always_comb begin
        core_start     = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 16'd0;
        mem_write_data = 32'd0;
        case (state_r)
            WNONCE: begin
                mem_we         = 1'b1;
                mem_addr       = msg_r + 16'd19;
                mem_write_data = nonce_r;
            end
            KICK: begin
                core_start = 1'b1;
            end
            WLOW, RUN, DRAIN: begin
                mem_we         = core_mem_we;
                mem_addr       = core_mem_addr;
                mem_write_data = core_mem_write_data;
            end
            RDREQ: begin
                mem_addr = out_r;
            end
            default: begin
                core_start = 1'b0;
            end
        endcase
    end

    // Sweep datapath: latched parameters, nonce stepping and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            nonce_r       <= 32'd0;
            count_r       <= 16'd0;
            msg_r         <= 16'd0;
            out_r         <= 16'd0;
            target_r      <= 32'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            found_r       <= 1'b0;
            found_nonce_r <= 32'd0;
            tried_r       <= 16'd0;
        end else begin
            done_r <= (state_r == FIN);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        nonce_r  <= base_nonce;
                        count_r  <= nonce_count;
                        msg_r    <= msg_addr;
                        out_r    <= out_addr;
                        target_r <= target;
                        tried_r  <= 16'd0;
                        found_r  <= 1'b0;
                        busy_r   <= (nonce_count != 16'd0);
                    end
                end
                CMP: begin
                    tried_r <= tried_inc_s;
                    if (hit_s) begin
                        found_r       <= 1'b1;
                        found_nonce_r <= nonce_r;
                    end else if (!last_s) begin
                        nonce_r <= nonce_r + 32'd1;
                    end
                end
                FIN: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= busy_r;
                end
            endcase
        end
    end

    assign busy              = busy_r;
    assign done              = done_r;
    assign found             = found_r;
    assign found_nonce       = found_nonce_r;
    assign tried             = tried_r;
    assign core_message_addr = msg_r;
    assign core_output_addr  = out_r;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: behavioural hash core and memory, reference sweep model
// feeding a scoreboard, and a monitor that checks results, nonce writes and bus handover.
module tb_nonce_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_nonce;
    logic [15:0] nonce_count;
    logic [15:0] msg_addr;
    logic [15:0] out_addr;
    logic [31:0] target;
    logic        busy, done, found, core_start;
    logic [31:0] found_nonce;
    logic [15:0] tried, core_message_addr, core_output_addr;
    logic        core_done, core_mem_we;
    logic [15:0] core_mem_addr;
    logic [31:0] core_mem_write_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    nonce_sweep_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .base_nonce(base_nonce),
        .nonce_count(nonce_count), .msg_addr(msg_addr), .out_addr(out_addr), .target(target),
        .busy(busy), .done(done), .found(found), .found_nonce(found_nonce), .tried(tried),
        .core_start(core_start), .core_message_addr(core_message_addr),
        .core_output_addr(core_output_addr), .core_done(core_done), .core_mem_we(core_mem_we),
        .core_mem_addr(core_mem_addr), .core_mem_write_data(core_mem_write_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=no-event", name);
    endtask

    // Digest word 0 as a function of the nonce found in the header slot
    logic        hit_en = 1'b0;
    logic [31:0] hit_nonce = 32'd0;
    logic [31:0] hit_val = 32'd0;
    logic [31:0] salt = 32'd0;

    function automatic logic [31:0] digest0(input logic [31:0] n);
        if (hit_en && n == hit_nonce) return hit_val;
        return 32'h8000_0000 | ((n * 32'h9E37_79B1) ^ salt);
    endfunction

    // Synchronous shared memory
    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    // Behavioural hash core: done low 200 cycles, 8 digest words, word 0 last
    int          core_cnt = 0;
    logic [31:0] core_nonce = 32'd0;
    logic [31:0] core_d0 = 32'd0;
    logic [15:0] core_slot;
    logic [15:0] core_widx;
    assign core_slot = core_message_addr + 16'd19;
    always @(posedge clk) begin
        if (reset) begin
            core_cnt <= 0;
        end else if (core_cnt == 0) begin
            if (core_start) begin
                core_cnt   <= 1;
                core_nonce <= mem[core_slot];
                core_d0    <= digest0(mem[core_slot]);
            end
        end else if (core_cnt >= 201) begin
            core_cnt <= 0;
        end else begin
            core_cnt <= core_cnt + 1;
        end
    end
    assign core_done           = !(core_cnt >= 1 && core_cnt <= 200);
    assign core_mem_we         = (core_cnt >= 194 && core_cnt <= 201);
    assign core_widx           = 16'(201 - core_cnt);
    assign core_mem_addr       = core_output_addr + core_widx;
    assign core_mem_write_data = (core_widx == 16'd0) ? core_d0 : (core_nonce ^ {16'd0, core_widx});

    // Scoreboard
    typedef struct {
        logic        f;
        logic [31:0] fn;
        int          tr;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] nonce_q[$];
    logic [15:0] cur_slot = 16'd0;
    int          cs_cnt = 0;

    task automatic push_expect(input logic [31:0] b, input logic [15:0] c, input logic [31:0] t);
        exp_t        e;
        logic [31:0] n;
        e.f  = 1'b0;
        e.fn = 32'd0;
        e.tr = 0;
        n    = b;
        for (int i = 0; i < int'(c); i++) begin
            nonce_q.push_back(n);
            e.tr++;
            if (digest0(n) <= t) begin
                e.f  = 1'b1;
                e.fn = n;
                break;
            end
            n = n + 32'd1;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: bus handover, nonce writes, and sweep results on done
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] wn;
        if (reset) begin
            cs_cnt = 0;
        end else begin
            if (core_start) cs_cnt++;
            if (core_cnt != 0) begin
                check("bus_passthrough", {15'd0, mem_we, mem_addr, mem_write_data},
                      {15'd0, core_mem_we, core_mem_addr, core_mem_write_data});
            end else if (mem_we) begin
                if (nonce_q.size() == 0) begin
                    fail("unexpected_ctrl_write");
                end else begin
                    wn = nonce_q.pop_front();
                    check("nonce_slot_addr", {48'd0, mem_addr}, {48'd0, cur_slot});
                    check("nonce_value", {32'd0, mem_write_data}, {32'd0, wn});
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("found", {63'd0, found}, {63'd0, e.f});
                    check("tried", {48'd0, tried}, 64'(e.tr));
                    if (e.f) check("found_nonce", {32'd0, found_nonce}, {32'd0, e.fn});
                    check("core_start_count", 64'(cs_cnt), 64'(e.tr));
                    check("busy_at_done", {63'd0, busy}, 64'd0);
                    check("nonce_writes_left", 64'(nonce_q.size()), 64'd0);
                end
                cs_cnt = 0;
            end
        end
    end

    task automatic run_sweep(input logic [31:0] b, input logic [15:0] c, input logic [15:0] m,
                             input logic [15:0] o, input logic [31:0] t);
        cur_slot = m + 16'd19;
        push_expect(b, c, t);
        @(negedge clk);
        base_nonce  = b;
        nonce_count = c;
        msg_addr    = m;
        out_addr    = o;
        target      = t;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        base_nonce  = $urandom;
        nonce_count = 16'($urandom);
        msg_addr    = 16'($urandom);
        out_addr    = 16'($urandom);
        target      = $urandom;
        if (c != 16'd0) check("busy_set", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            fail("done_timeout");
            exp_q.delete();
            nonce_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b, t;
        logic [15:0] c, m;
        int          k;
        reset = 1'b1;
        start = 1'b1;
        base_nonce = 32'd0; nonce_count = 16'd1; msg_addr = 16'd0; out_addr = 16'd0; target = 32'd0;

        // Reset state, with start held high against reset
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_results", {15'd0, found, tried, found_nonce}, 64'd0);
        check("rst_core_start", {63'd0, core_start}, 64'd0);
        check("rst_bus", {15'd0, mem_we, mem_addr, mem_write_data}, 64'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {63'd0, busy}, 64'd0);

        // Three nonces, no hit
        salt = $urandom;
        hit_en = 1'b0;
        run_sweep(32'h0000_0010, 16'd3, 16'h0100, 16'h0200, 32'd0);
        wait_idle(3 * 230 + 50);

        // Hit on the second nonce, digest exactly equal to target
        hit_en = 1'b1; hit_nonce = 32'h0000_0011; hit_val = 32'h0000_0005;
        run_sweep(32'h0000_0010, 16'd3, 16'h0100, 16'h0200, 32'h0000_0005);
        wait_idle(3 * 230 + 50);
        repeat (5) @(negedge clk);
        check("hold_found", {63'd0, found}, 64'd1);
        check("hold_found_nonce", {32'd0, found_nonce}, 64'h11);
        check("hold_tried", {48'd0, tried}, 64'd2);
        hit_en = 1'b0;

        // Zero count: done two cycles after start, no core activity
        cur_slot = 16'h0100 + 16'd19;
        push_expect(32'h0000_0020, 16'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        base_nonce = 32'h0000_0020; nonce_count = 16'd0; target = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done_early", {63'd0, done}, 64'd0);
        @(negedge clk);
        check("zero_done_latency", {63'd0, done}, 64'd1);
        wait_idle(20);

        // Nonce wrap from 0xFFFFFFFF to 0
        run_sweep(32'hFFFF_FFFF, 16'd2, 16'h3000, 16'h3100, 32'd0);
        wait_idle(2 * 230 + 50);

        // Reset in the middle of RUN, then a clean sweep
        run_sweep(32'h0000_0400, 16'd3, 16'h0500, 16'h0600, 32'd0);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_core_start", {63'd0, core_start}, 64'd0);
        check("midrst_mem_we", {63'd0, mem_we}, 64'd0);
        check("midrst_results", {15'd0, found, tried, found_nonce}, 64'd0);
        exp_q.delete();
        nonce_q.delete();
        reset = 1'b0;
        run_sweep(32'h0000_0400, 16'd2, 16'h0500, 16'h0600, 32'd0);
        wait_idle(2 * 230 + 50);

        // Start held from RUN through FIN must be ignored
        run_sweep(32'h0000_7000, 16'd2, 16'h0700, 16'h0800, 32'd0);
        repeat (100) @(negedge clk);
        base_nonce = 32'h0000_0001; nonce_count = 16'd5; target = 32'hFFFF_FFFF; start = 1'b1;
        k = 0;
        while (k < 1000 && !done) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (k >= 1000) fail("ignored_start_timeout");
        repeat (10) @(negedge clk);
        check("ignored_start_busy", {63'd0, busy}, 64'd0);
        check("ignored_start_pending", 64'(exp_q.size()), 64'd0);

        // Randomised sweeps
        for (int r = 0; r < 8; r++) begin
            b = (r % 3 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
            c = 16'($urandom_range(1, 4));
            salt = $urandom;
            hit_en = 1'($urandom_range(0, 1));
            hit_nonce = b + 32'($urandom_range(0, int'(c) - 1));
            hit_val = $urandom;
            t = hit_en ? (hit_val | 32'($urandom_range(0, 3))) : $urandom;
            m = 16'($urandom);
            run_sweep(b, c, m, m + 16'h0100, t);
            wait_idle(int'(c) * 230 + 50);
        end
        hit_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
